// File: rtl/axi_slave_sram.sv
// AXI4 slave responder backed by a word-addressed on-chip memory.
// Write (AW/W/B) and read (AR/R) engines are independent and may run concurrently.
module axi_slave_sram #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [SIZE_W-1:0]   awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [2:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [1:0]          arburst,
  input  logic [SIZE_W-1:0]   arsize,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          rresp,
  output logic                rvalid,
  output logic                rlast,
  input  logic                rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic f_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= MEM_BYTES;
  endfunction

  // Only FIXED/INCR at the full bus width are supported.
  function automatic logic f_burst_err(input logic [1:0] burst, input logic [SIZE_W-1:0] size);
    return (burst[1] == 1'b1) || (size != SIZE_W'(LSB));
  endfunction

  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [1:0] burst);
    return (burst == 2'b01) ? a + ADDR_W'(BYTES) : a;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------- write engine ----------------
  w_state_e          r_wstate, w_wstate_nxt;
  logic [ID_W-1:0]   r_wid;
  logic [ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]  r_wlen, r_wcnt;
  logic [1:0]        r_wburst;
  logic              r_wbad;
  logic [2:0]        r_werr, w_werr_nxt;
  logic              w_whs, w_wlast_exp, w_woob, w_wen;

  assign w_whs       = (r_wstate == W_DATA) && wvalid;
  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_woob      = f_oob(r_waddr);
  assign w_wen       = w_whs && !r_wbad && !w_woob;

  // NOTE: state is updated with <= so every always_ff sees pre-edge values; = here would race.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nxt;
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (awvalid)                w_wstate_nxt = W_DATA;
      W_DATA:  if (wvalid && w_wlast_exp)  w_wstate_nxt = W_RESP;
      W_RESP:  if (bready)                 w_wstate_nxt = W_IDLE;
      default:                             w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (r_wstate)
      W_IDLE:  awready = 1'b1;
      W_DATA:  wready  = 1'b1;
      W_RESP:  bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign bid   = r_wid;
  assign bresp = r_werr;

  // DECERR is sticky and outranks any SLVERR cause.
  always_comb begin
    w_werr_nxt = r_werr;
    if (r_werr != RESP_DECERR) begin
      if (w_woob)                                w_werr_nxt = RESP_DECERR;
      else if (r_wbad || (wlast != w_wlast_exp)) w_werr_nxt = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wburst <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= RESP_OKAY;
    end else if (r_wstate == W_IDLE && awvalid) begin
      r_wid    <= awid;
      r_waddr  <= awaddr;
      r_wlen   <= awlen;
      r_wcnt   <= '0;
      r_wburst <= awburst;
      r_wbad   <= f_burst_err(awburst, awsize);
      r_werr   <= RESP_OKAY;
    end else if (w_whs) begin
      r_werr  <= w_werr_nxt;
      r_waddr <= f_next(r_waddr, r_wburst);
      if (!w_wlast_exp) r_wcnt <= r_wcnt + LEN_W'(1);
    end
  end

  // NOTE: the memory array has no reset; contents survive rst_ni and only valid beats write it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_wen) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) r_mem[r_waddr[LSB +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e          r_rstate, w_rstate_nxt;
  logic [ID_W-1:0]   r_rid;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rlen, r_rcnt;
  logic [1:0]        r_rburst;
  logic              r_rbad;
  logic [DATA_W-1:0] r_rdata, w_fetch_data;
  logic [2:0]        r_rresp, w_fetch_resp;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_fetch_bad, w_ar_hs, w_r_hs, w_rlast;

  assign w_ar_hs      = (r_rstate == R_IDLE) && arvalid;
  assign w_r_hs       = (r_rstate == R_DATA) && rready;
  assign w_rlast      = (r_rcnt == r_rlen);
  assign w_fetch_addr = w_ar_hs ? araddr : r_raddr;
  assign w_fetch_bad  = w_ar_hs ? f_burst_err(arburst, arsize) : r_rbad;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (arvalid)           w_rstate_nxt = R_DATA;
      R_DATA:  if (rready && w_rlast) w_rstate_nxt = R_IDLE;
      default:                        w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_rstate == R_IDLE);
    rvalid  = (r_rstate == R_DATA);
    rlast   = (r_rstate == R_DATA) && w_rlast;
  end

  assign rid   = r_rid;
  assign rdata = r_rdata;
  assign rresp = r_rresp;

  always_comb begin
    w_fetch_data = r_mem[w_fetch_addr[LSB +: IDX_W]];
    w_fetch_resp = RESP_OKAY;
    if (f_oob(w_fetch_addr)) begin
      w_fetch_data = '0;
      w_fetch_resp = RESP_DECERR;
    end else if (w_fetch_bad) begin
      w_fetch_data = '0;
      w_fetch_resp = RESP_SLVERR;
    end
  end

  // The register always holds the next beat; r_raddr points one beat ahead of rdata.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rburst <= '0;
      r_rbad   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rid    <= arid;
      r_rlen   <= arlen;
      r_rcnt   <= '0;
      r_rburst <= arburst;
      r_rbad   <= w_fetch_bad;
      r_rdata  <= w_fetch_data;
      r_rresp  <= w_fetch_resp;
      r_raddr  <= f_next(araddr, arburst);
    end else if (w_r_hs && !w_rlast) begin
      r_rcnt  <= r_rcnt + LEN_W'(1);
      r_rdata <= w_fetch_data;
      r_rresp <= w_fetch_resp;
      r_raddr <= f_next(r_raddr, r_rburst);
    end
  end

endmodule

// File: tb/tb_axi_slave_sram.sv
// Self-checking bench for axi_slave_sram: directed vector table, corner-case sequences,
// and randomized bursts checked against an array-based memory model.
module tb_axi_slave_sram;

  logic        clk_i, rst_ni;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awvalid, awready;
  logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0]  bid;    logic [2:0] bresp; logic bvalid, bready;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [1:0] arburst;
  logic [2:0]  arsize; logic arvalid, arready;
  logic [3:0]  rid;    logic [31:0] rdata; logic [2:0] rresp; logic rvalid, rlast, rready;

  axi_slave_sram dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [256];
  logic [31:0] wr_data   [256];
  logic [3:0]  wr_strb   [256];
  logic [31:0] exp_rdata [256];
  logic [2:0]  exp_rresp [256];
  logic [31:0] got_rdata [256];
  logic [2:0]  got_rresp [256];
  logic        got_rlast [256];
  logic [3:0]  got_rid   [256];

  function automatic logic [2:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input logic [2:0] size,
                                             input int early_beat);
    logic [31:0] a;
    bit dec, slv, bad, sent_last;
    a = addr; dec = 0; slv = 0;
    bad = (burst > 2'd1) || (size != 3'd2);
    for (int b = 0; b <= int'(len); b++) begin
      sent_last = (early_beat >= 0) ? (b == early_beat) : (b == int'(len));
      if (a >= 32'd1024) dec = 1;
      else if (!bad)
        for (int k = 0; k < 4; k++)
          if (wr_strb[b][k]) model_mem[a[9:2]][k*8 +: 8] = wr_data[b][k*8 +: 8];
      if (bad || (sent_last != (b == int'(len)))) slv = 1;
      if (burst == 2'b01) a = a + 32'd4;
    end
    return dec ? 3'b011 : (slv ? 3'b010 : 3'b000);
  endfunction

  function automatic void model_read(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] size);
    logic [31:0] a;
    bit bad;
    a = addr;
    bad = (burst > 2'd1) || (size != 3'd2);
    for (int b = 0; b <= int'(len); b++) begin
      if (a >= 32'd1024)  begin exp_rdata[b] = '0; exp_rresp[b] = 3'b011; end
      else if (bad)       begin exp_rdata[b] = '0; exp_rresp[b] = 3'b010; end
      else                begin exp_rdata[b] = model_mem[a[9:2]]; exp_rresp[b] = 3'b000; end
      if (burst == 2'b01) a = a + 32'd4;
    end
  endfunction

  // ---------------- bus drivers (called at a negedge) ----------------
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int early_beat,
                           output logic [2:0] resp, output logic [3:0] resp_id);
    int t;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    for (t = 0; t < 50 && !awready; t++) @(negedge clk_i);
    check("aw_timeout", t >= 50, 0);
    @(negedge clk_i);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wr_data[b]; wstrb = wr_strb[b];
      wlast = (early_beat >= 0) ? (b == early_beat) : (b == int'(len));
      wvalid = 1'b1;
      for (t = 0; t < 50 && !wready; t++) @(negedge clk_i);
      check("w_timeout", t >= 50, 0);
      @(negedge clk_i);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    for (t = 0; t < 50 && !bvalid; t++) @(negedge clk_i);
    check("b_timeout", t >= 50, 0);
    resp = bresp; resp_id = bid;
    @(negedge clk_i);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int rmode,
                          output int nb);
    int t;
    logic held, h_last;
    logic [31:0] h_data;
    logic [2:0] h_resp;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    for (t = 0; t < 50 && !arready; t++) @(negedge clk_i);
    check("ar_timeout", t >= 50, 0);
    @(negedge clk_i);
    arvalid = 1'b0;
    nb = 0; held = 1'b0; h_data = '0; h_resp = '0; h_last = 1'b0;
    for (t = 0; t < 4000 && nb <= int'(len); t++) begin
      if (held) begin
        check("r_stall_rvalid", rvalid, 1);
        check("r_stall_rdata", rdata, h_data);
        check("r_stall_rresp", rresp, h_resp);
        check("r_stall_rlast", rlast, h_last);
      end
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = (t % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      held = 1'b0;
      if (rvalid && rready) begin
        got_rdata[nb] = rdata; got_rresp[nb] = rresp; got_rlast[nb] = rlast; got_rid[nb] = rid;
        nb++;
      end else if (rvalid) begin
        held = 1'b1; h_data = rdata; h_resp = rresp; h_last = rlast;
      end
      @(negedge clk_i);
    end
    rready = 1'b0;
    check("r_idle_after_last", rvalid, 0);
  endtask

  task automatic cmp_read(input string tag, input logic [3:0] id, input logic [7:0] len, input int nb);
    check({tag, "_beats"}, nb, int'(len) + 1);
    for (int b = 0; b <= int'(len) && b < nb; b++) begin
      check($sformatf("%s_rdata[%0d]", tag, b), got_rdata[b], exp_rdata[b]);
      check($sformatf("%s_rresp[%0d]", tag, b), got_rresp[b], exp_rresp[b]);
      check($sformatf("%s_rlast[%0d]", tag, b), got_rlast[b], b == int'(len));
      check($sformatf("%s_rid[%0d]", tag, b), got_rid[b], id);
    end
  endtask

  // ---------------- directed single-beat vectors ----------------
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_rresp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    logic [3:0] r_id;
    logic [31:0] old_word, new_word;
    int nb, nb_w;
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [1:0] burst;
    int t;

    vecs[0]  = '{4'h3, 32'h10,       2'b01, 3'd2, 32'hDEADBEEF, 4'hF, 3'b000, 32'hDEADBEEF, 3'b000};
    vecs[1]  = '{4'h5, 32'h0,        2'b01, 3'd2, 32'h11223344, 4'hF, 3'b000, 32'h11223344, 3'b000};
    vecs[2]  = '{4'h6, 32'h0,        2'b00, 3'd2, 32'hAAAAAAAA, 4'h1, 3'b000, 32'h112233AA, 3'b000};
    vecs[3]  = '{4'h7, 32'h0,        2'b00, 3'd2, 32'hBBBBBBBB, 4'h8, 3'b000, 32'hBB2233AA, 3'b000};
    vecs[4]  = '{4'h9, 32'h400,      2'b01, 3'd2, 32'hCAFEF00D, 4'hF, 3'b011, 32'h0,        3'b011};
    vecs[5]  = '{4'hA, 32'h0,        2'b01, 3'd2, 32'h0,        4'h0, 3'b000, 32'hBB2233AA, 3'b000};
    vecs[6]  = '{4'h1, 32'h10,       2'b01, 3'd1, 32'h12345678, 4'hF, 3'b010, 32'h0,        3'b010};
    vecs[7]  = '{4'h2, 32'h10,       2'b10, 3'd2, 32'h12345678, 4'hF, 3'b010, 32'h0,        3'b010};
    vecs[8]  = '{4'h4, 32'h10,       2'b11, 3'd2, 32'h12345678, 4'hF, 3'b010, 32'h0,        3'b010};
    vecs[9]  = '{4'hB, 32'h10,       2'b01, 3'd2, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 3'b000};
    vecs[10] = '{4'hF, 32'h3FC,      2'b01, 3'd2, 32'h0BADCAFE, 4'hF, 3'b000, 32'h0BADCAFE, 3'b000};
    vecs[11] = '{4'hE, 32'h3FC,      2'b01, 3'd2, 32'hFFFFFFFF, 4'h6, 3'b000, 32'h0BFFFFFE, 3'b000};
    vecs[12] = '{4'hD, 32'hFFFFFFFC, 2'b01, 3'd2, 32'h55555555, 4'hF, 3'b011, 32'h0,        3'b011};
    vecs[13] = '{4'hC, 32'h3FC,      2'b01, 3'd2, 32'h0,        4'h0, 3'b000, 32'h0BFFFFFE, 3'b000};

    rst_ni = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset state
    check("rst_awready", awready, 1); check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);   check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);     check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);     check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);

    // Fill the whole memory with a max-length (256-beat) INCR burst, then read it back.
    for (int i = 0; i < 256; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    axi_write(4'h8, 32'h0, 8'd255, 2'b01, 3'd2, -1, r, r_id);
    check("fill_bresp", r, model_write(32'h0, 8'd255, 2'b01, 3'd2, -1));
    check("fill_bid", r_id, 4'h8);
    model_read(32'h0, 8'd255, 2'b01, 3'd2);
    axi_read(4'h9, 32'h0, 8'd255, 2'b01, 3'd2, 2, nb);
    cmp_read("fill_rd", 4'h9, 8'd255, nb);

    // Table-driven single-beat write/read pairs
    for (int v = 0; v < 14; v++) begin
      wr_data[0] = vecs[v].wdata; wr_strb[0] = vecs[v].wstrb;
      axi_write(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].burst, vecs[v].size, -1, r, r_id);
      void'(model_write(vecs[v].addr, 8'd0, vecs[v].burst, vecs[v].size, -1));
      check($sformatf("vec%0d_bresp", v), r, vecs[v].exp_bresp);
      check($sformatf("vec%0d_bid", v), r_id, vecs[v].id);
      axi_read(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].burst, vecs[v].size, 0, nb);
      check($sformatf("vec%0d_beats", v), nb, 1);
      check($sformatf("vec%0d_rdata", v), got_rdata[0], vecs[v].exp_rdata);
      check($sformatf("vec%0d_rresp", v), got_rresp[0], vecs[v].exp_rresp);
      check($sformatf("vec%0d_rlast", v), got_rlast[0], 1);
      check($sformatf("vec%0d_rid", v), got_rid[0], vecs[v].id);
    end

    // INCR burst, read back with rready toggling 1,0,1,0
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    axi_write(4'h2, 32'h40, 8'd3, 2'b01, 3'd2, -1, r, r_id);
    void'(model_write(32'h40, 8'd3, 2'b01, 3'd2, -1));
    check("incr_bresp", r, 3'b000);
    for (int i = 0; i < 4; i++) begin exp_rdata[i] = 32'(i + 1); exp_rresp[i] = 3'b000; end
    axi_read(4'h6, 32'h40, 8'd3, 2'b01, 3'd2, 1, nb);
    cmp_read("incr_rd", 4'h6, 8'd3, nb);

    // WRAP read: SLVERR with zero data on every beat
    for (int i = 0; i < 4; i++) begin exp_rdata[i] = 32'h0; exp_rresp[i] = 3'b010; end
    axi_read(4'h7, 32'h40, 8'd3, 2'b10, 3'd2, 0, nb);
    cmp_read("wrap_rd", 4'h7, 8'd3, nb);

    // wlast asserted early on beat 0 of a 2-beat burst
    wr_data[0] = 32'h01010101; wr_data[1] = 32'h02020202; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    axi_write(4'h3, 32'h50, 8'd1, 2'b01, 3'd2, 0, r, r_id);
    void'(model_write(32'h50, 8'd1, 2'b01, 3'd2, 0));
    check("early_wlast_bresp", r, 3'b010);

    // B backpressure: bvalid/bid/bresp hold, awready stays low
    awid = 4'hC; awaddr = 32'h60; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    for (t = 0; t < 50 && !awready; t++) @(negedge clk_i);
    @(negedge clk_i);
    awvalid = 1'b0;
    wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    for (t = 0; t < 50 && !wready; t++) @(negedge clk_i);
    @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0;
    for (t = 0; t < 50 && !bvalid; t++) @(negedge clk_i);
    check("bp_b_timeout", t >= 50, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", bvalid, 1); check("bp_bid", bid, 4'hC);
      check("bp_bresp", bresp, 0);   check("bp_awready", awready, 0);
      @(negedge clk_i);
    end
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    check("bp_bvalid_after", bvalid, 0);
    check("bp_awready_after", awready, 1);
    wr_data[0] = 32'h5A5A5A5A; wr_strb[0] = 4'hF;
    void'(model_write(32'h60, 8'd0, 2'b01, 3'd2, -1));

    // Concurrent 8-beat read and 8-beat write to disjoint regions
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    model_read(32'h100, 8'd7, 2'b01, 3'd2);
    fork
      axi_write(4'h4, 32'h200, 8'd7, 2'b01, 3'd2, -1, r, r_id);
      axi_read(4'h5, 32'h100, 8'd7, 2'b01, 3'd2, 0, nb);
    join
    check("conc_bresp", r, model_write(32'h200, 8'd7, 2'b01, 3'd2, -1));
    cmp_read("conc_rd", 4'h5, 8'd7, nb);
    model_read(32'h200, 8'd7, 2'b01, 3'd2);
    axi_read(4'h1, 32'h200, 8'd7, 2'b01, 3'd2, 2, nb);
    cmp_read("conc_wr_back", 4'h1, 8'd7, nb);

    // Read capture colliding with a write to the same word returns the old value
    old_word = model_mem[8'h20];
    new_word = ~old_word;
    awid = 4'h1; awaddr = 32'h80; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    for (t = 0; t < 50 && !awready; t++) @(negedge clk_i);
    @(negedge clk_i);
    awvalid = 1'b0;
    wdata = new_word; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'h2; araddr = 32'h80; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    check("coll_wready", wready, 1);
    check("coll_arready", arready, 1);
    @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check("coll_rvalid", rvalid, 1);
    check("coll_rdata_old", rdata, old_word);
    check("coll_rresp", rresp, 0);
    rready = 1'b1;
    @(negedge clk_i);
    rready = 1'b0;
    bready = 1'b1;
    for (t = 0; t < 50 && !bvalid; t++) @(negedge clk_i);
    check("coll_bresp", bresp, 0);
    @(negedge clk_i);
    bready = 1'b0;
    model_mem[8'h20] = new_word;
    axi_read(4'h3, 32'h80, 8'd0, 2'b01, 3'd2, 0, nb);
    check("coll_rdata_new", got_rdata[0], new_word);

    // INCR address wraps past 2^32 back into range
    model_read(32'hFFFFFFFC, 8'd2, 2'b01, 3'd2);
    axi_read(4'hA, 32'hFFFFFFFC, 8'd2, 2'b01, 3'd2, 0, nb);
    cmp_read("addr_wrap", 4'hA, 8'd2, nb);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      id    = 4'($urandom);
      addr  = 32'($urandom_range(0, 270)) * 32'd4;
      len   = 8'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
        axi_write(id, addr, len, burst, 3'd2, -1, r, r_id);
        check($sformatf("rnd%0d_bresp", it), r, model_write(addr, len, burst, 3'd2, -1));
        check($sformatf("rnd%0d_bid", it), r_id, id);
      end else begin
        model_read(addr, len, burst, 3'd2);
        axi_read(id, addr, len, burst, 3'd2, int'($urandom_range(0, 2)), nb);
        cmp_read($sformatf("rnd%0d", it), id, len, nb);
      end
    end

    // Reset pulse during beat 2 of an 8-beat read aborts it
    model_read(32'h40, 8'd7, 2'b01, 3'd2);
    arid = 4'h6; araddr = 32'h40; arlen = 8'd7; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    for (t = 0; t < 50 && !arready; t++) @(negedge clk_i);
    @(negedge clk_i);
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rstmid_beat2_rdata", rdata, exp_rdata[2]);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    rready = 1'b0;
    check("rstmid_rvalid", rvalid, 0);
    check("rstmid_arready", arready, 1);
    check("rstmid_rlast", rlast, 0);
    check("rstmid_rdata", rdata, 0);
    check("rstmid_awready", awready, 1);
    check("rstmid_bvalid", bvalid, 0);
    @(negedge clk_i);
    check("rstmid_rvalid_hold", rvalid, 0);
    axi_read(4'h7, 32'h40, 8'd7, 2'b01, 3'd2, 0, nb);
    cmp_read("rstmid_new_rd", 4'h7, 8'd7, nb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_sram.md
Name: axi_slave_sram

Overview:
- Generic AXI4 slave (responder) backed by an on-chip word-addressed memory array.
- Attaches to any slave port of axi_bus in the same way slave_0_sdram and slave_1_aes do.
- Used as scratch RAM for DMA/CPU traffic and as a reference responder for exercising the bus and the dmac master port.
- Write and read channels are independent and may run concurrently.

Parameters:
- ID_W, 4, AXI ID width (matches `ID_BITS)
- ADDR_W, 32, address width (matches `ADDR_WIDTH)
- LEN_W, 8, burst length field width (matches `LEN_BITS)
- SIZE_W, 3, burst size field width (matches `SIZE_BITS)
- DATA_W, 32, data width (matches `DATA_WIDTH); power of 2, >= 32
- DEPTH, 256, memory depth in DATA_W words; power of 2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/LEN_W/SIZE_W/2  AW payload
- awvalid  in  1;  awready  out  1
- wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  W payload
- wvalid  in  1;  wready  out  1
- bid  out  ID_W;  bresp  out  3;  bvalid  out  1;  bready  in  1
- arid/araddr/arlen/arburst/arsize  in  ID_W/ADDR_W/LEN_W/2/SIZE_W  AR payload
- arvalid  in  1;  arready  out  1
- rid  out  ID_W;  rdata  out  DATA_W;  rresp  out  3;  rvalid  out  1;  rlast  out  1;  rready  in  1

Behaviour:
- Clock and reset:
  - Single clock clk_i. Reset is synchronous and active-low on rst_ni.
  - Reset forces both FSMs to idle, all outputs to 0 except awready=1 and arready=1 in the cycle after reset releases, and all counters to 0.
  - Memory contents are not reset.
  - Reset asserted mid-burst aborts the burst; no B or R response is issued for it.
- Response encoding (3-bit): OKAY=3'b000, SLVERR=3'b010, DECERR=3'b011.
- Addressing:
  - BYTES = DATA_W/8; LSB = log2(BYTES); word index = addr[LSB+log2(DEPTH)-1:LSB].
  - A beat is out of range if addr >= DEPTH*BYTES.
- Bursts:
  - FIXED (00): address held for every beat.
  - INCR (01): address += BYTES per beat; wraps modulo 2^ADDR_W.
  - WRAP (10) and reserved (11): burst_err.
  - awsize/arsize != LSB: burst_err.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1. On awvalid&&awready, latch id/addr/len/burst, clear beat counter and err, go to W_DATA.
  - W_DATA: wready=1, awready=0. Each W handshake writes the bytes enabled by wstrb, but only if there is no burst_err and the beat is in range.
    - Out-of-range beat sets sticky DECERR. burst_err sets SLVERR. DECERR has priority.
    - wlast != (beat==len) on any beat sets SLVERR (unless DECERR is set).
    - After the beat with count==len, go to W_RESP. Completion is determined by the counter, not by wlast.
  - W_RESP: bvalid=1, bid=latched id, bresp=err code. Hold until bready; then go to W_IDLE with bvalid=0.
  - Back-to-back: awready returns in the cycle after the B handshake.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch id/len/burst. In the same edge, register rdata/rresp for beat 0 from araddr. Next cycle rvalid=1.
  - R_DATA: rid=latched id; rlast=1 when beat==len.
    - On each rvalid&&rready: if last, go to R_IDLE with rvalid=0. Otherwise advance the address and register the next beat's rdata/rresp.
    - rdata/rresp/rlast are held stable while rvalid && !rready.
    - Out-of-range beat: rdata=0, rresp=DECERR (per beat). burst_err: rdata=0, rresp=SLVERR on every beat.
  - Throughput: 1 beat/cycle with rready held high. First beat latency is 1 cycle after the AR handshake.
- Collisions:
  - A read capture and a write to the same word in the same cycle: the read returns the old value.
  - Concurrent non-colliding accesses are unaffected.
- len arithmetic: beats = awlen+1 (1..2^LEN_W). The beat counter is LEN_W bits wide and never overflows.

Test Plan:
- Single write, then single read: AW addr=0x10, len=0, INCR, size=2, wdata=0xDEADBEEF, wstrb=4'hF -> bresp=0, bid echoes awid. Read 0x10 -> rdata=0xDEADBEEF, rlast=1, rresp=0.
- INCR burst: write len=3 at 0x40, data 1,2,3,4; read back len=3 with rready toggling 1,0,1,0 -> data 1,2,3,4 in order, each stable during stalls, rlast only on the 4th beat.
- Strobes and FIXED: write 0x11223344 to 0x0, then FIXED len=1 to 0x0 with data 0xAAAAAAAA/wstrb 4'h1 and data 0xBBBBBBBB/wstrb 4'h8 -> read 0x0 = 0xBB2233AA.
- Errors:
  - Write at addr DEPTH*4 -> bresp=3'b011, memory unchanged.
  - WRAP read -> every beat rresp=3'b010, rdata=0.
  - wlast early on beat 0 of len=1 -> bresp=3'b010 after 2 beats.
- Backpressure and concurrency: bready held low for 5 cycles -> bvalid held with stable bid/bresp, awready=0 throughout. Simultaneous read len=7 and write len=7 to disjoint regions -> both complete, 8 beats each, correct data.
- Reset mid-burst: rst_ni low for 1 cycle during beat 2 of a len=7 read -> next cycle rvalid=0, arready=1. A new read completes normally.
